traffic_sequencer: RTL and testbench

TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

---
 rtl/traffic_pkg.sv | 60 ++++++
 rtl/traffic_sequencer_if.sv | 34 +++
 rtl/phase_timer.sv | 33 +++
 rtl/traffic_leds.sv | 26 ++
 rtl/traffic_sequencer.sv | 137 +++++++++++++
 tb/tb_traffic_sequencer.sv | 224 ++++++++++++++++++++++
 6 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic sequencer slice.
//   - Lamp bit positions of the 7-bit lamp vector, which both the sequencer
//     and the LEDs decoder use.
//   - State codes and the state typedef. The `phase` debug output carries
//     these codes.
//   - A helper that maps a state to its fixed lamp pattern.
package traffic_pkg;

    localparam int unsigned NumLamps       = 7;
    localparam int unsigned LampRedMain    = 0;
    localparam int unsigned LampYellowMain = 1;
    localparam int unsigned LampGreenMain  = 2;
    localparam int unsigned LampRedSide    = 3;
    localparam int unsigned LampYellowSide = 4;
    localparam int unsigned LampGreenSide  = 5;
    localparam int unsigned LampWalk       = 6;

    typedef enum logic [2:0] {
        StMainGreen  = 3'd0,
        StMainYellow = 3'd1,
        StWalk       = 3'd2,
        StSideGreen  = 3'd3,
        StSideYellow = 3'd4
    } state_e;

    // Fixed lamp pattern of each state. An unused code falls back to all-red.
    function automatic logic [NumLamps-1:0] lamps_for(state_e st);
        logic [NumLamps-1:0] l;
        l = '0;
        unique case (st)
            StMainGreen: begin
                l[LampGreenMain] = 1'b1;
                l[LampRedSide]   = 1'b1;
            end
            StMainYellow: begin
                l[LampYellowMain] = 1'b1;
                l[LampRedSide]    = 1'b1;
            end
            StWalk: begin
                l[LampRedMain] = 1'b1;
                l[LampRedSide] = 1'b1;
                l[LampWalk]    = 1'b1;
            end
            StSideGreen: begin
                l[LampRedMain]   = 1'b1;
                l[LampGreenSide] = 1'b1;
            end
            StSideYellow: begin
                l[LampRedMain]    = 1'b1;
                l[LampYellowSide] = 1'b1;
            end
            default: begin
                l[LampRedMain] = 1'b1;
                l[LampRedSide] = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_sequencer_if.sv
// Bundles the sequencer's I/O. The clock and reset stay outside it.
//   tick        : one-cycle timebase enable
//   side_sensor : a vehicle is waiting on the side road (level)
//   walk_req    : pedestrian button
//   signal      : registered lamp vector (bit layout in traffic_pkg)
//   phase       : registered state code, for debug
// Modports:
//   master : the environment, which drives the inputs and watches the lamps.
//   slave  : the sequencer.
interface traffic_sequencer_if;

    logic       tick;
    logic       side_sensor;
    logic       walk_req;
    logic [6:0] signal;
    logic [2:0] phase;

    modport master (
        output tick,
        output side_sensor,
        output walk_req,
        input  signal,
        input  phase
    );

    modport slave (
        input  tick,
        input  side_sensor,
        input  walk_req,
        output signal,
        output phase
    );

endinterface

// File: rtl/phase_timer.sv
// Tick counter with an expiry compare.
// The counter advances only on tick cycles. It saturates at duration-1, so a
// phase that is held past its minimum keeps reporting expiry on each tick.
//   clk      : clock
//   reset    : synchronous, active-high
//   clear    : forces the count to 0 on the next edge
//   tick     : timebase enable
//   duration : phase length in ticks (1..15)
//   expired  : high on the tick that completes the phase
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [3:0] duration,
    output logic       expired
);

    logic [3:0] count_q;
    logic       at_end;

    assign at_end  = (count_q == (duration - 4'd1));
    assign expired = tick && at_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= 4'd0;
        end else if (tick && !at_end) begin
            count_q <= count_q + 4'd1;
        end
    end

endmodule

// File: rtl/traffic_leds.sv
// Splits the sequencer's lamp vector into one line per LED driver. The top
// level connects the sequencer's signal output to this block.
//   signal      : lamp vector from traffic_sequencer
//   red_main .. walk : one output per lamp
module traffic_leds
    import traffic_pkg::*;
(
    input  logic [NumLamps-1:0] signal,
    output logic                red_main,
    output logic                yellow_main,
    output logic                green_main,
    output logic                red_side,
    output logic                yellow_side,
    output logic                green_side,
    output logic                walk
);

    assign red_main    = signal[LampRedMain];
    assign yellow_main = signal[LampYellowMain];
    assign green_main  = signal[LampGreenMain];
    assign red_side    = signal[LampRedSide];
    assign yellow_side = signal[LampYellowSide];
    assign green_side  = signal[LampGreenSide];
    assign walk        = signal[LampWalk];

endmodule

// File: rtl/traffic_sequencer.sv
// Traffic-light sequencer for a main road, a side road and a pedestrian
// crossing.
// Main road green is held until a side vehicle or a pedestrian asks for
// service. Side green may be extended once per visit while a vehicle is still
// present. A button press is latched in walk_pending until the WALK phase
// serves it.
//   clk   : clock
//   reset : synchronous, active-high; forces MAIN_GREEN at once, with no
//           clearance interval
//   bus   : traffic_sequencer_if.slave (tick, side_sensor, walk_req in;
//           signal and phase out)
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned T_GREEN  = 6,
    parameter int unsigned T_EXT    = 3,
    parameter int unsigned T_YELLOW = 2,
    parameter int unsigned T_WALK   = 3
) (
    input  logic                clk,
    input  logic                reset,
    traffic_sequencer_if.slave  bus
);

    localparam logic [3:0] DurGreen  = 4'(T_GREEN);
    localparam logic [3:0] DurExt    = 4'(T_EXT);
    localparam logic [3:0] DurYellow = 4'(T_YELLOW);
    localparam logic [3:0] DurWalk   = 4'(T_WALK);

    state_e        state_q, state_d;
    logic          ext_used_q, ext_used_d;
    logic          walk_pending_q, walk_pending_d;
    logic [6:0]    signal_q;
    logic [3:0]    duration;
    logic          timer_clear;
    logic          expired;

    phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .tick     (bus.tick),
        .duration (duration),
        .expired  (expired)
    );

    // Once the extension has started, the side-green timer runs for T_EXT.
    always_comb begin
        duration = DurGreen;
        unique case (state_q)
            StMainGreen:  duration = DurGreen;
            StMainYellow: duration = DurYellow;
            StWalk:       duration = DurWalk;
            StSideGreen:  duration = ext_used_q ? DurExt : DurGreen;
            StSideYellow: duration = DurYellow;
            default:      duration = DurGreen;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        ext_used_d     = ext_used_q;
        walk_pending_d = walk_pending_q;
        timer_clear    = 1'b0;

        unique case (state_q)
            StMainGreen: begin
                if (expired && (bus.side_sensor || walk_pending_q)) begin
                    state_d = StMainYellow;
                end
            end
            StMainYellow: begin
                if (expired) begin
                    state_d = walk_pending_q ? StWalk : StSideGreen;
                end
            end
            StWalk: begin
                if (expired) begin
                    state_d = StMainGreen;
                end
            end
            StSideGreen: begin
                if (expired) begin
                    if (bus.side_sensor && !ext_used_q) begin
                        // Stay in side green and restart the timer for the extension.
                        ext_used_d  = 1'b1;
                        timer_clear = 1'b1;
                    end else begin
                        state_d = StSideYellow;
                    end
                end
            end
            StSideYellow: begin
                if (expired) begin
                    state_d = StMainGreen;
                end
            end
            default: state_d = StMainGreen;
        endcase

        if (state_d != state_q) begin
            timer_clear = 1'b1;
        end
        if ((state_d == StSideGreen) && (state_q != StSideGreen)) begin
            ext_used_d = 1'b0;
        end

        // Entering WALK clears the latch, even when walk_req is high on the same cycle.
        if ((state_d == StWalk) && (state_q != StWalk)) begin
            walk_pending_d = 1'b0;
        end else if (bus.walk_req && (state_q != StWalk)) begin
            walk_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StMainGreen;
            ext_used_q     <= 1'b0;
            walk_pending_q <= 1'b0;
            signal_q       <= lamps_for(StMainGreen);
        end else if (bus.tick) begin
            state_q        <= state_d;
            ext_used_q     <= ext_used_d;
            walk_pending_q <= walk_pending_d;
            // The lamps are taken from the next state, so they change on the same edge as the state.
            signal_q       <= lamps_for(state_d);
        end else begin
            // With no tick, only the pedestrian latch can change.
            walk_pending_q <= walk_pending_d;
        end
    end

    assign bus.signal = signal_q;
    assign bus.phase  = state_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
module tb_traffic_sequencer;
    import traffic_pkg::*;

    localparam int unsigned TG = 6;
    localparam int unsigned TE = 3;
    localparam int unsigned TY = 2;
    localparam int unsigned TW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    traffic_sequencer_if bus ();

    traffic_sequencer #(
        .T_GREEN  (TG),
        .T_EXT    (TE),
        .T_YELLOW (TY),
        .T_WALK   (TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic red_main, yellow_main, green_main, red_side, yellow_side, green_side, walk;

    traffic_leds u_leds (
        .signal      (bus.signal),
        .red_main    (red_main),
        .yellow_main (yellow_main),
        .green_main  (green_main),
        .red_side    (red_side),
        .yellow_side (yellow_side),
        .green_side  (green_side),
        .walk        (walk)
    );

    // Reference model. It tracks the current phase and how many ticks of the
    // phase have elapsed, and applies the phase rules with plain arithmetic.
    typedef enum int {MdMainGreen, MdMainYellow, MdWalk, MdSideGreen, MdSideYellow} md_e;
    md_e m_ph;
    int  m_done;
    bit  m_pend;
    bit  m_ext;

    typedef struct {
        logic [6:0] sig;
        logic [2:0] ph;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [6:0] lamps_of(md_e p);
        case (p)
            MdMainGreen:  return 7'b0001100;
            MdMainYellow: return 7'b0001010;
            MdWalk:       return 7'b1001001;
            MdSideGreen:  return 7'b0100001;
            default:      return 7'b0010001;
        endcase
    endfunction

    function automatic logic [2:0] code_of(md_e p);
        case (p)
            MdMainGreen:  return StMainGreen;
            MdMainYellow: return StMainYellow;
            MdWalk:       return StWalk;
            MdSideGreen:  return StSideGreen;
            default:      return StSideYellow;
        endcase
    endfunction

    function automatic bit lamps_safe(logic [6:0] s);
        bit main_go, side_go;
        main_go = s[1] | s[2];
        side_go = s[4] | s[5];
        return !(main_go && side_go) && !(s[6] && (main_go || side_go));
    endfunction

    task automatic model_step(bit rst, bit tk, bit ss, bit wr);
        md_e nx;
        int  len;
        bit  in_walk;
        if (rst) begin
            m_ph = MdMainGreen; m_done = 0; m_pend = 0; m_ext = 0;
            return;
        end
        nx = m_ph;
        in_walk = (m_ph == MdWalk);
        if (tk) begin
            case (m_ph)
                MdMainGreen:                len = TG;
                MdSideGreen:                len = m_ext ? TE : TG;
                MdMainYellow, MdSideYellow: len = TY;
                default:                    len = TW;
            endcase
            if (m_done + 1 < len) begin
                m_done++;
            end else begin
                case (m_ph)
                    MdMainGreen:  if (ss || m_pend) nx = MdMainYellow;
                    MdMainYellow: nx = m_pend ? MdWalk : MdSideGreen;
                    MdWalk:       nx = MdMainGreen;
                    MdSideGreen: begin
                        if (ss && !m_ext) begin
                            m_ext = 1; m_done = 0;
                        end else begin
                            nx = MdSideYellow;
                        end
                    end
                    default:      nx = MdMainGreen;
                endcase
            end
        end
        if (nx != m_ph) begin
            m_done = 0;
            if (nx == MdSideGreen) m_ext = 0;
        end
        if (nx == MdWalk && !in_walk) m_pend = 0;
        else if (wr && !in_walk) m_pend = 1;
        m_ph = nx;
    endtask

    // Applies one cycle of stimulus, queues the expected result and waits.
    task automatic drive(bit rst, bit tk, bit ss, bit wr);
        exp_t e;
        reset = rst;
        bus.tick = tk;
        bus.side_sensor = ss;
        bus.walk_req = wr;
        model_step(rst, tk, ss, wr);
        e.sig = lamps_of(m_ph);
        e.ph  = code_of(m_ph);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: after each edge, compares the DUT outputs with the oldest
    // queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.signal !== e.sig) begin
                errors++;
                $display("FAIL signal t=%0t got %b want %b", $time, bus.signal, e.sig);
            end
            checks++;
            if (bus.phase !== e.ph) begin
                errors++;
                $display("FAIL phase t=%0t got %0d want %0d", $time, bus.phase, e.ph);
            end
            checks++;
            if ({walk, green_side, yellow_side, red_side, green_main, yellow_main, red_main}
                !== e.sig) begin
                errors++;
                $display("FAIL leds t=%0t got %b want %b", $time,
                         {walk, green_side, yellow_side, red_side, green_main, yellow_main,
                          red_main}, e.sig);
            end
        end
        checks++;
        assert (lamps_safe(bus.signal)) else begin
            errors++;
            $display("FAIL conflict t=%0t got %b want no conflicting lamps", $time, bus.signal);
        end
    end

    initial begin
        int n;
        // Idle: no demand, so main green is held.
        drive(1, 1, 0, 0);
        for (int i = 0; i < 30; i++) drive(0, 1, 0, 0);

        // Side sensor held from reset: full cycle with one extension.
        drive(1, 1, 1, 0);
        for (int i = 0; i < 45; i++) drive(0, 1, 1, 0);

        // Pedestrian press at cycle 2, plus a press during WALK.
        drive(1, 1, 0, 0);
        for (int i = 0; i < 30; i++) drive(0, 1, 0, (i == 2) || (i == 9));

        // Slow timebase: tick every 4th cycle.
        drive(1, 1, 1, 0);
        for (int i = 0; i < 120; i++) drive(0, (i % 4) == 3, 1, (i == 50));

        // Reset on the 3rd cycle of side green.
        drive(1, 1, 1, 0);
        n = 0;
        while (!(m_ph == MdSideGreen && m_done == 2) && n < 100) begin
            drive(0, 1, 1, 0);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL reach_side_green got %0d cycles want fewer than 100", n);
        end
        drive(1, 1, 1, 0);
        for (int i = 0; i < 25; i++) drive(0, 1, 1, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 300) == 0, ($urandom % 3) != 0, ($urandom % 3) == 0,
                  ($urandom % 30) == 0);
        end

        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
